vga_timing_gen: RTL and testbench

Parametrised raster timing generator, the next generation of the fixed 640x480 VGA controller. It produces sync, blanking, pixel coordinates, line/frame strobes and a frame counter for any mode described by its porch/sync parameters. All outputs are registered and mutually aligned. It sits between the pixel clock domain and the pixel/framebuffer logic, and drives the VGA connector pins directly.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_axis_counter.sv | 47 ++++
 rtl/vga_timing_gen.sv | 173 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: mode constants, sync-polarity constants and the
// line/frame total helper shared by the raster timing generator.
package vga_timing_pkg;

  // Sync polarity encodings for the H_POL / V_POL parameters
  localparam int SYNC_ACTIVE_LOW  = 0;
  localparam int SYNC_ACTIVE_HIGH = 1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock (25 MHz in practice)
  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;
  localparam int VGA640_H_POL     = SYNC_ACTIVE_LOW;
  localparam int VGA640_V_POL     = SYNC_ACTIVE_LOW;

  // 800x600 @ 72 Hz, 50 MHz pixel clock
  localparam int SVGA800_H_DISPLAY = 800;
  localparam int SVGA800_H_FRONT   = 56;
  localparam int SVGA800_H_SYNC    = 120;
  localparam int SVGA800_H_BACK    = 64;
  localparam int SVGA800_V_DISPLAY = 600;
  localparam int SVGA800_V_FRONT   = 37;
  localparam int SVGA800_V_SYNC    = 6;
  localparam int SVGA800_V_BACK    = 23;
  localparam int SVGA800_H_POL     = SYNC_ACTIVE_HIGH;
  localparam int SVGA800_V_POL     = SYNC_ACTIVE_HIGH;

  // Full period of one axis (pixels per line or lines per frame)
  function automatic int calc_total(input int display, input int front,
                                    input int sync_w, input int back);
    return display + front + sync_w + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis. Counts 0..TOTAL-1 on inc, flags the
// wrap, and decodes the active region and the sync window from the count.
module vga_axis_counter #(
  parameter int CNT_W      = 10,
  parameter int TOTAL      = 800,
  parameter int DISPLAY    = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic             clk_25MHz,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             in_sync
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             at_last;

  // Compare in 32 bits so a TOTAL of exactly 2^CNT_W still decodes correctly
  assign at_last = (int'(cnt_reg) == TOTAL - 1);
  assign wrap    = inc & at_last;
  assign active  = (int'(cnt_reg) < DISPLAY);
  assign in_sync = (int'(cnt_reg) >= SYNC_START) && (int'(cnt_reg) < SYNC_END);
  assign cnt     = cnt_reg;

  // Next count: advance on inc, return to 0 after the last position
  always_comb begin
    cnt_next = cnt_reg;
    if (inc) begin
      cnt_next = at_last ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  // Position register
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator. All outputs are
// decoded from the h/v counters and registered once, so they describe the
// counter state of the previous enabled cycle and stay mutually aligned.
// Optional feature macro: VGA_TIMING_LOOKAHEAD_EN adds next_x/next_y/
// next_valid, the unregistered decode that leads pixel_x/pixel_y/video_on
// by one cycle (for framebuffer RAMs with a registered read).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = VGA640_H_DISPLAY,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_DISPLAY = VGA640_V_DISPLAY,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter int H_POL     = VGA640_H_POL,
  parameter int V_POL     = VGA640_V_POL,
  parameter int CNT_W     = 10,
  parameter int FCNT_W    = 16
) (
  input  logic              clk_25MHz,
  input  logic              rst,
  input  logic              en,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [CNT_W-1:0]  pixel_x,
  output logic [CNT_W-1:0]  pixel_y,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_count
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic [CNT_W-1:0]  next_x,
  output logic [CNT_W-1:0]  next_y,
  output logic              next_valid
`endif
);

  localparam int   H_TOTAL = calc_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int   V_TOTAL = calc_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam logic H_ACT   = (H_POL != 0);
  localparam logic V_ACT   = (V_POL != 0);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             v_inc;
  logic             h_active;
  logic             v_active;
  logic             h_in_sync;
  logic             v_in_sync;

  assign v_inc = en & h_wrap;

  vga_axis_counter #(
    .CNT_W      (CNT_W),
    .TOTAL      (H_TOTAL),
    .DISPLAY    (H_DISPLAY),
    .SYNC_START (H_DISPLAY + H_FRONT),
    .SYNC_END   (H_DISPLAY + H_FRONT + H_SYNC)
  ) u_h_axis (
    .clk_25MHz (clk_25MHz),
    .rst       (rst),
    .inc       (en),
    .cnt       (h_cnt),
    .wrap      (h_wrap),
    .active    (h_active),
    .in_sync   (h_in_sync)
  );

  vga_axis_counter #(
    .CNT_W      (CNT_W),
    .TOTAL      (V_TOTAL),
    .DISPLAY    (V_DISPLAY),
    .SYNC_START (V_DISPLAY + V_FRONT),
    .SYNC_END   (V_DISPLAY + V_FRONT + V_SYNC)
  ) u_v_axis (
    .clk_25MHz (clk_25MHz),
    .rst       (rst),
    .inc       (v_inc),
    .cnt       (v_cnt),
    .wrap      (v_wrap),
    .active    (v_active),
    .in_sync   (v_in_sync)
  );

  logic [FCNT_W-1:0] frame_cnt_reg;

  // Completed-frame tally; v_wrap only fires on the h wrap of the last line
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (v_wrap) begin
      frame_cnt_reg <= frame_cnt_reg + FCNT_W'(1);
    end
  end

  logic             hsync_next;
  logic             vsync_next;
  logic             video_on_next;
  logic [CNT_W-1:0] pixel_x_next;
  logic [CNT_W-1:0] pixel_y_next;
  logic             line_start_next;
  logic             frame_start_next;

  // Decode the current counter state into the values the outputs will take
  always_comb begin
    video_on_next    = h_active & v_active;
    hsync_next       = h_in_sync ? H_ACT : ~H_ACT;
    vsync_next       = v_in_sync ? V_ACT : ~V_ACT;
    pixel_x_next     = video_on_next ? h_cnt : '0;
    pixel_y_next     = video_on_next ? v_cnt : '0;
    line_start_next  = (h_cnt == '0);
    frame_start_next = (h_cnt == '0) && (v_cnt == '0);
  end

  logic              hsync_reg;
  logic              vsync_reg;
  logic              video_on_reg;
  logic [CNT_W-1:0]  pixel_x_reg;
  logic [CNT_W-1:0]  pixel_y_reg;
  logic              line_start_reg;
  logic              frame_start_reg;
  logic [FCNT_W-1:0] frame_count_reg;

  // Output stage: capture the decode while enabled, hold (strobes cleared)
  // while paused. frame_count samples the tally here so its step lands on
  // the same cycle as the frame_start that opens the next frame.
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      hsync_reg       <= ~H_ACT;
      vsync_reg       <= ~V_ACT;
      video_on_reg    <= 1'b0;
      pixel_x_reg     <= '0;
      pixel_y_reg     <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_count_reg <= '0;
    end else if (en) begin
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      video_on_reg    <= video_on_next;
      pixel_x_reg     <= pixel_x_next;
      pixel_y_reg     <= pixel_y_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      frame_count_reg <= frame_cnt_reg;
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign pixel_x     = pixel_x_reg;
  assign pixel_y     = pixel_y_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_count = frame_count_reg;

`ifdef VGA_TIMING_LOOKAHEAD_EN
  assign next_x     = pixel_x_next;
  assign next_y     = pixel_y_next;
  assign next_valid = video_on_next;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench. A default-mode instance covers the line
// level (first pixel, hsync window, line spacing, en pause); a tiny mode
// (15 x 11, 2-bit frame counter) covers frame level, vsync, frame_count
// wrap and mid-frame reset; a third tiny instance has both polarities high.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int n_d = 0;
  int n_s = 0;

  // default-mode instance
  logic        rst_d, en_d, hs_d, vs_d, vo_d, ls_d, fs_d;
  logic [9:0]  px_d, py_d;
  logic [15:0] fc_d;
  // tiny-mode instances (dut_p shares rst_s/en_s)
  logic        rst_s, en_s, hs_s, vs_s, vo_s, ls_s, fs_s;
  logic [3:0]  px_s, py_s;
  logic [1:0]  fc_s;
  logic        hs_p, vs_p, vo_p, ls_p, fs_p;
  logic [3:0]  px_p, py_p;
  logic [1:0]  fc_p;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [9:0]  nx_d, ny_d;
  logic        nv_d;
  logic [3:0]  nx_s, ny_s, nx_p, ny_p;
  logic        nv_s, nv_p;
`endif

  vga_timing_gen dut_d (
    .clk_25MHz (clk), .rst (rst_d), .en (en_d),
    .hsync (hs_d), .vsync (vs_d), .video_on (vo_d),
    .pixel_x (px_d), .pixel_y (py_d),
    .line_start (ls_d), .frame_start (fs_d), .frame_count (fc_d)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .next_x (nx_d), .next_y (ny_d), .next_valid (nv_d)
`endif
  );

  vga_timing_gen #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
    .H_POL (0), .V_POL (0), .CNT_W (4), .FCNT_W (2)
  ) dut_s (
    .clk_25MHz (clk), .rst (rst_s), .en (en_s),
    .hsync (hs_s), .vsync (vs_s), .video_on (vo_s),
    .pixel_x (px_s), .pixel_y (py_s),
    .line_start (ls_s), .frame_start (fs_s), .frame_count (fc_s)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .next_x (nx_s), .next_y (ny_s), .next_valid (nv_s)
`endif
  );

  vga_timing_gen #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
    .H_POL (1), .V_POL (1), .CNT_W (4), .FCNT_W (2)
  ) dut_p (
    .clk_25MHz (clk), .rst (rst_s), .en (en_s),
    .hsync (hs_p), .vsync (vs_p), .video_on (vo_p),
    .pixel_x (px_p), .pixel_y (py_p),
    .line_start (ls_p), .frame_start (fs_p), .frame_count (fc_p)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .next_x (nx_p), .next_y (ny_p), .next_valid (nv_p)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_d = 1'b1; rst_s = 1'b1; en_d = 1'b1; en_s = 1'b1;
    repeat (3) tick();
    checks++;
    if ({hs_d, vs_d, vo_d, ls_d, fs_d} !== 5'b11000)
      $display("FAIL reset_ctrl_d: got %b required 11000", {hs_d, vs_d, vo_d, ls_d, fs_d});
    else passes++;
    checks++;
    if (px_d !== 10'd0 || py_d !== 10'd0 || fc_d !== 16'd0)
      $display("FAIL reset_data_d: got x=%0d y=%0d fc=%0d required 0 0 0", px_d, py_d, fc_d);
    else passes++;
    checks++;
    if ({hs_s, vs_s, vo_s, ls_s, fs_s} !== 5'b11000 || px_s !== 4'd0 || py_s !== 4'd0 || fc_s !== 2'd0)
      $display("FAIL reset_s: got ctrl=%b x=%0d y=%0d fc=%0d", {hs_s, vs_s, vo_s, ls_s, fs_s}, px_s, py_s, fc_s);
    else passes++;
    checks++;
    if ({hs_p, vs_p} !== 2'b00)
      $display("FAIL reset_pol: got hs=%b vs=%b required 0 0", hs_p, vs_p);
    else passes++;
    $display("test_reset: %0d/%0d", passes, checks);
  endtask

  task automatic test_first_line();
    int h, v, hs_low, first_low, last_ls;
    logic e_vo, e_hs;
    logic [9:0] e_px, e_py;
`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic [9:0] p_nx, p_ny;
    logic p_nv;
    p_nx = '0; p_ny = '0; p_nv = 1'b0;
`endif
    hs_low = 0; first_low = -1; last_ls = -1;
    rst_d = 1'b0;
    for (int n = 1; n <= 1600; n++) begin
      tick();
      n_d = n;
      h = (n - 1) % 800;
      v = (n - 1) / 800;
      e_vo = (h < 640);
      e_px = e_vo ? 10'(h) : 10'd0;
      e_py = e_vo ? 10'(v) : 10'd0;
      e_hs = !(h >= 656 && h < 752);
      checks++;
      if (vo_d !== e_vo || px_d !== e_px || py_d !== e_py)
        $display("FAIL line_pixel n=%0d: got vo=%b x=%0d y=%0d required vo=%b x=%0d y=%0d", n, vo_d, px_d, py_d, e_vo, e_px, e_py);
      else passes++;
      checks++;
      if (hs_d !== e_hs || vs_d !== 1'b1)
        $display("FAIL line_sync n=%0d: got hs=%b vs=%b required hs=%b vs=1", n, hs_d, vs_d, e_hs);
      else passes++;
      checks++;
      if (ls_d !== (h == 0) || fs_d !== (n == 1) || fc_d !== 16'd0)
        $display("FAIL line_strobe n=%0d: got ls=%b fs=%b fc=%0d required ls=%b fs=%b fc=0", n, ls_d, fs_d, fc_d, (h == 0), (n == 1));
      else passes++;
`ifdef VGA_TIMING_LOOKAHEAD_EN
      if (n >= 2) begin
        checks++;
        if (px_d !== p_nx || py_d !== p_ny || vo_d !== p_nv)
          $display("FAIL lookahead_d n=%0d: got x=%0d y=%0d vo=%b required %0d %0d %b", n, px_d, py_d, vo_d, p_nx, p_ny, p_nv);
        else passes++;
      end
      p_nx = nx_d; p_ny = ny_d; p_nv = nv_d;
`endif
      if (hs_d === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = h;
      end
      if (ls_d === 1'b1) begin
        if (last_ls >= 0) begin
          checks++;
          if (n - last_ls != 800)
            $display("FAIL line_spacing: got %0d required 800", n - last_ls);
          else passes++;
        end
        last_ls = n;
      end
    end
    checks++;
    if (hs_low != 192 || first_low != 656)
      $display("FAIL hsync_width: got low=%0d first=%0d required 192 656", hs_low, first_low);
    else passes++;
    $display("test_first_line: %0d/%0d", passes, checks);
  endtask

  task automatic test_en_pause();
    while (n_d < 1701) begin tick(); n_d++; end
    checks++;
    if (px_d !== 10'd100 || py_d !== 10'd2 || vo_d !== 1'b1)
      $display("FAIL pause_entry: got x=%0d y=%0d vo=%b required 100 2 1", px_d, py_d, vo_d);
    else passes++;
    en_d = 1'b0;
    for (int k = 0; k < 37; k++) begin
      tick();
      checks++;
      if (px_d !== 10'd100 || py_d !== 10'd2 || vo_d !== 1'b1 || ls_d !== 1'b0 || fs_d !== 1'b0 || hs_d !== 1'b1)
        $display("FAIL pause_hold k=%0d: got x=%0d y=%0d vo=%b ls=%b fs=%b hs=%b", k, px_d, py_d, vo_d, ls_d, fs_d, hs_d);
      else passes++;
    end
    en_d = 1'b1;
    tick(); n_d++;
    checks++;
    if (px_d !== 10'd101) $display("FAIL pause_resume: got x=%0d required 101", px_d);
    else passes++;
    tick(); n_d++;
    checks++;
    if (px_d !== 10'd102) $display("FAIL pause_resume2: got x=%0d required 102", px_d);
    else passes++;
    // pause while line_start is showing: the strobe must not repeat
    while (n_d < 2401) begin tick(); n_d++; end
    checks++;
    if (ls_d !== 1'b1 || px_d !== 10'd0 || py_d !== 10'd3)
      $display("FAIL strobe_pre: got ls=%b x=%0d y=%0d required 1 0 3", ls_d, px_d, py_d);
    else passes++;
    en_d = 1'b0;
    tick();
    checks++;
    if (ls_d !== 1'b0 || px_d !== 10'd0 || py_d !== 10'd3 || vo_d !== 1'b1)
      $display("FAIL strobe_pause: got ls=%b x=%0d y=%0d vo=%b required 0 0 3 1", ls_d, px_d, py_d, vo_d);
    else passes++;
    en_d = 1'b1;
    tick(); n_d++;
    checks++;
    if (ls_d !== 1'b0 || px_d !== 10'd1)
      $display("FAIL strobe_resume: got ls=%b x=%0d required 0 1", ls_d, px_d);
    else passes++;
    $display("test_en_pause: %0d/%0d", passes, checks);
  endtask

  task automatic test_frames();
    int p, f, r, h, v, vs_low, last_fs;
    logic e_vo, e_hs, e_vs;
    logic [3:0] e_px, e_py;
`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic [3:0] p_nx, p_ny;
    logic p_nv;
    p_nx = '0; p_ny = '0; p_nv = 1'b0;
`endif
    vs_low = 0; last_fs = -1;
    rst_s = 1'b0;
    for (int n = 1; n <= 662; n++) begin
      tick();
      n_s = n;
      p = n - 1; f = p / 165; r = p % 165; h = r % 15; v = r / 15;
      e_vo = (h < 8) && (v < 6);
      e_px = e_vo ? 4'(h) : 4'd0;
      e_py = e_vo ? 4'(v) : 4'd0;
      e_hs = !(h >= 10 && h < 13);
      e_vs = !(v >= 7 && v < 9);
      checks++;
      if (vo_s !== e_vo || px_s !== e_px || py_s !== e_py)
        $display("FAIL frame_pixel n=%0d: got vo=%b x=%0d y=%0d required vo=%b x=%0d y=%0d", n, vo_s, px_s, py_s, e_vo, e_px, e_py);
      else passes++;
      checks++;
      if (hs_s !== e_hs || vs_s !== e_vs || hs_p !== ~e_hs || vs_p !== ~e_vs)
        $display("FAIL frame_sync n=%0d: got hs=%b vs=%b hs_p=%b vs_p=%b required hs=%b vs=%b", n, hs_s, vs_s, hs_p, vs_p, e_hs, e_vs);
      else passes++;
      checks++;
      if (ls_s !== (h == 0) || fs_s !== (r == 0))
        $display("FAIL frame_strobe n=%0d: got ls=%b fs=%b required ls=%b fs=%b", n, ls_s, fs_s, (h == 0), (r == 0));
      else passes++;
      checks++;
      if (fc_s !== 2'(f))
        $display("FAIL frame_count n=%0d: got %0d required %0d", n, fc_s, 2'(f));
      else passes++;
`ifdef VGA_TIMING_LOOKAHEAD_EN
      if (n >= 2) begin
        checks++;
        if (px_s !== p_nx || py_s !== p_ny || vo_s !== p_nv || (!nv_s && (nx_s !== 4'd0 || ny_s !== 4'd0)))
          $display("FAIL lookahead_s n=%0d: got x=%0d y=%0d vo=%b required %0d %0d %b", n, px_s, py_s, vo_s, p_nx, p_ny, p_nv);
        else passes++;
      end
      p_nx = nx_s; p_ny = ny_s; p_nv = nv_s;
`endif
      if (f == 0 && vs_s === 1'b0) vs_low++;
      if (fs_s === 1'b1) begin
        if (last_fs >= 0) begin
          checks++;
          if (n - last_fs != 165)
            $display("FAIL frame_spacing: got %0d required 165", n - last_fs);
          else passes++;
        end
        last_fs = n;
      end
    end
    checks++;
    if (vs_low != 30) $display("FAIL vsync_width: got %0d required 30", vs_low);
    else passes++;
    $display("test_frames: %0d/%0d", passes, checks);
  endtask

  task automatic test_reset_mid();
    while (n_s < 875) begin tick(); n_s++; end
    checks++;
    if (px_s !== 4'd4 || py_s !== 4'd3 || fc_s !== 2'd1)
      $display("FAIL mid_position: got x=%0d y=%0d fc=%0d required 4 3 1", px_s, py_s, fc_s);
    else passes++;
    rst_s = 1'b1; en_s = 1'b0;
    tick();
    checks++;
    if ({hs_s, vs_s, vo_s, ls_s, fs_s} !== 5'b11000 || px_s !== 4'd0 || py_s !== 4'd0 || fc_s !== 2'd0)
      $display("FAIL mid_reset: got ctrl=%b x=%0d y=%0d fc=%0d required 11000 0 0 0", {hs_s, vs_s, vo_s, ls_s, fs_s}, px_s, py_s, fc_s);
    else passes++;
    checks++;
    if ({hs_p, vs_p} !== 2'b00) $display("FAIL mid_reset_pol: got hs=%b vs=%b required 0 0", hs_p, vs_p);
    else passes++;
    rst_s = 1'b0; en_s = 1'b1;
    tick();
    checks++;
    if (vo_s !== 1'b1 || fs_s !== 1'b1 || ls_s !== 1'b1 || px_s !== 4'd0 || py_s !== 4'd0 || fc_s !== 2'd0)
      $display("FAIL mid_restart: got vo=%b fs=%b ls=%b x=%0d y=%0d fc=%0d", vo_s, fs_s, ls_s, px_s, py_s, fc_s);
    else passes++;
    tick();
    checks++;
    if (px_s !== 4'd1 || fs_s !== 1'b0) $display("FAIL mid_restart2: got x=%0d fs=%b required 1 0", px_s, fs_s);
    else passes++;
    $display("test_reset_mid: %0d/%0d", passes, checks);
  endtask

  initial begin
    rst_d = 1'b1; rst_s = 1'b1; en_d = 1'b0; en_s = 1'b0;
    test_reset();
    test_first_line();
    test_en_pause();
    test_frames();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
